// File: rtl/acc16_seq_if.sv
// acc16_seq_if -- operand/handshake bundle for acc16_seq.
//   master: drives start, len, din, din_valid; observes din_ready, sum,
//           carry_cnt, busy, done.
//   slave : the accumulator side (acc16_seq).
// CNT_W must match the CNT_W of the attached acc16_seq.
interface acc16_seq_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic [15:0]      din;
    logic             din_valid;
    logic             din_ready;
    logic [15:0]      sum;
    logic [CNT_W-1:0] carry_cnt;
    logic             busy;
    logic             done;

    modport master (
        output start, len, din, din_valid,
        input  din_ready, sum, carry_cnt, busy, done
    );

    modport slave (
        input  start, len, din, din_valid,
        output din_ready, sum, carry_cnt, busy, done
    );
endinterface

// File: rtl/acc16_seq.sv
// acc16_seq -- sequential 16-bit accumulator with carry-out counting.
//   clk       : clock, all state changes on rising edge
//   rst       : asynchronous active-high reset
//   bus.slave : start/len launch a run of len operands (0 = 2^CNT_W);
//               din/din_valid/din_ready transfer operands; sum and
//               carry_cnt report the running/final result; busy is high
//               while accumulating; done pulses one cycle at run end.
// Build option: define ACC16_SAT_EN to saturate sum at 16'hFFFF on carry.
// The adder is four 4-bit carry-lookahead groups (acc16_cla4) with a
// second lookahead level across the group generate/propagate terms.

// One 4-bit CLA group: sum bits plus group generate/propagate.
module acc16_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                  (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    // Group terms are independent of cin so the upper level can look ahead.
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;
endmodule

module acc16_seq #(
    parameter int CNT_W = 4
) (
    input logic        clk,
    input logic        rst,
    acc16_seq_if.slave bus
);
    localparam int NUM_GRP = 4;
    localparam logic [CNT_W:0] RUN_MAX = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0] RUN_ONE = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e           state_q, state_d;
    logic [15:0]      sum_q, sum_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
    // One extra bit so len=0 can be held as 2^CNT_W operands.
    logic [CNT_W:0]   rem_q, rem_d;

    logic [NUM_GRP-1:0][3:0] grp_s;
    logic [NUM_GRP-1:0]      grp_g;
    logic [NUM_GRP-1:0]      grp_p;
    logic [NUM_GRP:0]        grp_c;
    logic [15:0]             add_s;
    logic                    add_co;

    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_cla
        acc16_cla4 u_cla (
            .a  (sum_q[gi*4 +: 4]),
            .b  (bus.din[gi*4 +: 4]),
            .cin(grp_c[gi]),
            .s  (grp_s[gi]),
            .gg (grp_g[gi]),
            .pg (grp_p[gi])
        );
    end

    // Group carries straight from G/P terms (carry-in 0), no ripple.
    always_comb begin
        grp_c = '0;
        for (int k = 0; k < NUM_GRP; k++) begin
            for (int j = 0; j <= k; j++) begin
                logic term;
                term = grp_g[j];
                for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
                grp_c[k+1] = grp_c[k+1] | term;
            end
        end
    end

    assign add_s  = grp_s;
    assign add_co = grp_c[NUM_GRP];

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_cnt_d = carry_cnt_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sum_d       = '0;
                    carry_cnt_d = '0;
                    rem_d       = (bus.len == '0) ? RUN_MAX : {1'b0, bus.len};
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.din_valid) begin
`ifdef ACC16_SAT_EN
                    // Once at 16'hFFFF any nonzero operand carries again,
                    // so saturation persists without a separate flag.
                    sum_d = add_co ? 16'hFFFF : add_s;
`else
                    sum_d = add_s;
`endif
                    if (add_co) carry_cnt_d = carry_cnt_q + 1'b1;
                    rem_d = rem_q - RUN_ONE;
                    if (rem_q == RUN_ONE) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_cnt_q <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_cnt_q <= carry_cnt_d;
            rem_q       <= rem_d;
        end
    end

    assign bus.din_ready = (state_q == ACCUM);
    assign bus.busy      = (state_q == ACCUM);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_cnt = carry_cnt_q;
endmodule

// File: tb/tb_acc16_seq.sv
// tb_acc16_seq -- randomized/directed bench for acc16_seq with a scoreboard.
// The driver computes each run's expected result with plain 17-bit
// arithmetic and queues it; a negedge monitor pops and compares on done.
module tb_acc16_seq;
    localparam int CNT_W = 4;

    typedef struct {
        logic [15:0]      s;
        logic [CNT_W-1:0] c;
        int               n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc16_seq_if #(.CNT_W(CNT_W)) bus ();
    acc16_seq #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   xfers = 0;
    logic [15:0] op_buf [0:15];
    bit   pat [0:6] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one operand folded into a running result.
    task automatic model_add(inout logic [15:0] s, inout int c, input logic [15:0] d);
        int t;
        t = int'(s) + int'(d);
        s = t[15:0];
        if (t > 65535) begin
            c = c + 1;
`ifdef ACC16_SAT_EN
            s = 16'hFFFF;
`endif
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            xfers = 0;
        end else begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("final_sum", {16'h0, bus.sum}, {16'h0, e.s});
                    check("final_carry_cnt", {28'h0, bus.carry_cnt}, {28'h0, e.c});
                    check("xfers_at_done", xfers, e.n);
                end
                xfers = 0;
            end
            if (bus.din_valid && bus.din_ready) xfers++;
        end
    end

    // mode: 0 always valid, 1 fixed stall pattern, 2 random valid.
    // hold: keep start high through ACCUM and DONE.
    // abort_after: >0 asserts reset after that many transfers.
    task automatic run(input logic [CNT_W-1:0] lenv, input int mode, input bit hold,
                       input int abort_after);
        int n, i, cyc, c, got;
        logic [15:0] s, ps;
        int pc;
        bit v, rdy;
        exp_t e;
        n = (lenv == 0) ? (1 << CNT_W) : int'(lenv);
        s = 16'h0; c = 0;
        for (int k = 0; k < n; k++) model_add(s, c, op_buf[k]);
        if (abort_after == 0) begin
            e.s = s; e.c = c[CNT_W-1:0]; e.n = n;
            exp_q.push_back(e);
        end

        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = lenv; bus.din_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = hold;
        i = 0; cyc = 0; ps = 16'h0; pc = 0;
        while (i < n && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[cyc % 7];
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.din_valid = v;
            bus.din = op_buf[i];
            rdy = bus.din_ready;
            @(posedge clk); #1;
            if (v && rdy) begin
                model_add(ps, pc, op_buf[i]);
                i++;
                check("running_sum", {16'h0, bus.sum}, {16'h0, ps});
            end
            cyc++;
            if (abort_after > 0 && i == abort_after) break;
        end
        bus.din_valid = 1'b0;
        if (cyc >= 400) check("run_timeout", 32'd1, 32'd0);

        if (abort_after > 0) begin
            rst = 1'b1;
            #1;
            check("abort_sum", {16'h0, bus.sum}, 32'h0);
            check("abort_carry_cnt", {28'h0, bus.carry_cnt}, 32'h0);
            check("abort_busy", {31'h0, bus.busy}, 32'h0);
            check("abort_ready", {31'h0, bus.din_ready}, 32'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            bus.start = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("abort_idle_busy", {31'h0, bus.busy}, 32'h0);
            check("abort_idle_sum", {16'h0, bus.sum}, 32'h0);
            return;
        end

        got = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; break; end
        end
        check("done_seen", got, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'h0, bus.busy}, 32'h0);
        check("idle_done", {31'h0, bus.done}, 32'h0);
        check("hold_sum", {16'h0, bus.sum}, {16'h0, s});
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.din = '0; bus.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum", {16'h0, bus.sum}, 32'h0);
        check("rst_carry_cnt", {28'h0, bus.carry_cnt}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_ready", {31'h0, bus.din_ready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run.
        op_buf[0] = 16'h0001; op_buf[1] = 16'h0002; op_buf[2] = 16'h0003;
        run(4'd3, 0, 1'b0, 0);
        // Wrap / saturate.
        op_buf[0] = 16'hFFFF; op_buf[1] = 16'h0002;
        run(4'd2, 0, 1'b0, 0);
        // Stalls and bursts.
        for (int k = 0; k < 4; k++) op_buf[k] = 16'h1111;
        run(4'd4, 1, 1'b0, 0);
        // len=0 means 16 operands.
        for (int k = 0; k < 16; k++) op_buf[k] = 16'h1000;
        run(4'd0, 0, 1'b0, 0);
        // start held through the run.
        op_buf[0] = 16'h0005; op_buf[1] = 16'h0005;
        run(4'd2, 0, 1'b1, 0);
        // Reset mid-run after two operands (sum and carry nonzero by then).
        op_buf[0] = 16'hFFFF; op_buf[1] = 16'h0002; op_buf[2] = 16'h0003;
        run(4'd3, 0, 1'b0, 2);
        // Recovery after the aborted run.
        op_buf[0] = 16'h0001; op_buf[1] = 16'h0002; op_buf[2] = 16'h0003;
        run(4'd3, 0, 1'b0, 0);
        // Randomized runs.
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 16; k++)
                op_buf[k] = (r % 3 == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                         : 16'($urandom);
            run(4'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc16_seq.md
ACC16_SEQ -- requirements
Module: acc16_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the width of len and carry_cnt.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-high.
REQ-004 Port start, input, 1: begin an accumulation run; sampled only in IDLE.
REQ-005 Port len, input, CNT_W: number of operands in the run; 0 means 2^CNT_W; captured on accepted start.
REQ-006 Port din, input, 16: operand word.
REQ-007 Port din_valid, input, 1: din holds a valid operand.
REQ-008 Port din_ready, output, 1: block accepts din this cycle.
REQ-009 Port sum, output, 16: running and final accumulated sum.
REQ-010 Port carry_cnt, output, CNT_W: count of carry-outs generated during the run.
REQ-011 Port busy, output, 1: high in ACCUM.
REQ-012 Port done, output, 1: one-cycle pulse on run completion.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-014 In IDLE, start=1 SHALL clear sum and carry_cnt, load the remaining-operand counter from len (0 -> 2^CNT_W), and move to ACCUM next cycle.
REQ-015 din_ready SHALL be 1 only in ACCUM; a transfer occurs on a cycle with din_valid=1 and din_ready=1.
REQ-016 On each transfer, {carry, sum_next} = sum + din, 17-bit, carry-in 0, computed with 4-bit group generate/propagate carry lookahead; sum SHALL update the same edge (1-cycle latency).
REQ-017 On a transfer with carry=1, carry_cnt SHALL increment, wrapping modulo 2^CNT_W.
REQ-018 Cycles with din_valid=0 in ACCUM SHALL hold all state (stall); there is no timeout.
REQ-019 The transfer that completes the len-th operand SHALL move the FSM to DONE; no further operands are accepted.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 sum and carry_cnt SHALL hold their final values in DONE and IDLE until the next accepted start.
REQ-022 start asserted in ACCUM or DONE SHALL be ignored.

Reset
REQ-023 rst=1 SHALL, asynchronously and at any point, force IDLE, sum=16'h0000, carry_cnt=0, operand counter=0, busy=0, done=0, din_ready=0.
REQ-024 A run interrupted by reset SHALL be discarded; no done pulse SHALL occur for it.

Configuration
REQ-025 With ACC16_SAT_EN defined, a transfer producing carry=1 SHALL set sum to 16'hFFFF, and sum SHALL stay 16'hFFFF for the rest of the run; carry_cnt still increments.
REQ-026 Without ACC16_SAT_EN, sum SHALL wrap modulo 2^16.

Verification
REQ-027 Reset mid-run: assert rst during ACCUM after 2 operands -> next cycle IDLE, sum=0, carry_cnt=0, no done pulse.
REQ-028 Basic run: start with len=3, din 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> sum=16'h0006, carry_cnt=0, done pulses 1 cycle after the 3rd transfer.
REQ-029 Wrap run: len=2, din 16'hFFFF then 16'h0002 -> sum=16'h0001 and carry_cnt=1 without the macro; sum=16'hFFFF with ACC16_SAT_EN.
REQ-030 Stalls and bursts: len=4, din_valid toggling 1,0,0,1,1,0,1 with din=16'h1111 -> sum=16'h4444 and done only after the 4th transfer.
REQ-031 len=0: 16 operands of 16'h1000 -> sum=16'h0000, carry_cnt=1, done after exactly 16 transfers.
REQ-032 start asserted throughout ACCUM (len=2, din=16'h0005) -> run unaffected, sum=16'h000A, and a new run starts from IDLE only after done.
